// File: rtl/draw_arbiter.sv
// draw_arbiter: shares the framebuffer pixel-write port between two drawers and a full-screen clear sequencer
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req0/x0/y0/pen0/gnt0  requester 0 pixel request and same-cycle grant
//   req1/x1/y1/pen1/gnt1  requester 1 pixel request and same-cycle grant
//   clear_start           pulse that starts a full-screen clear sweep
//   clear_done            pulse when the last clear pixel is accepted
//   busy                  high while the clear sweep owns the port
//   oob_drop              pulse when a granted pixel is out of range and discarded
//   fb_valid/x/y/pen      registered output pixel, held while fb_ready is low
//   fb_ready              framebuffer accepts the output pixel
//
// Build option: define DRAW_ARB_FIXED_PRIORITY_EN for fixed priority (requester 0
// always wins); otherwise burst-limited round-robin is used.
module draw_arbiter #(
  parameter int XMAX  = 640,
  parameter int YMAX  = 480,
  parameter int BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [9:0] x0,
  input  logic [8:0] y0,
  input  logic       pen0,
  output logic       gnt0,
  input  logic       req1,
  input  logic [9:0] x1,
  input  logic [8:0] y1,
  input  logic       pen1,
  output logic       gnt1,
  input  logic       clear_start,
  output logic       clear_done,
  output logic       busy,
  output logic       oob_drop,
  output logic       fb_valid,
  output logic [9:0] fb_x,
  output logic [8:0] fb_y,
  output logic       fb_pen,
  input  logic       fb_ready
);
  typedef enum logic {ARB, CLEAR} state_t;
  localparam logic [9:0] XL = 10'(XMAX - 1);
  localparam logic [8:0] YL = 9'(YMAX - 1);
  state_t     state_q;
  logic       fb_valid_q, fb_pen_q, clr_last_q;
  logic [9:0] fb_x_q, cx_q, gx;
  logic [8:0] fb_y_q, cy_q, gy;
  logic       free, sel, gp, gnt_any, in_range, clr_load, clr_final;
  assign free = !fb_valid_q || fb_ready;
`ifdef DRAW_ARB_FIXED_PRIORITY_EN
  assign sel = !req0;
`else
  localparam logic [3:0] BL = 4'(BURST);
  logic       last_q, last_d, keep;
  logic [3:0] burst_q, burst_d;
  // burst_q == 0 means nobody holds priority yet, so the non-last requester wins
  assign keep = burst_q != 4'd0 && burst_q < BL;
  assign sel  = (req0 && req1) ? (keep ? last_q : !last_q) : req1;
  always_comb begin
    last_d  = gnt_any ? sel : last_q;
    burst_d = !gnt_any ? burst_q :
              (sel != last_q || burst_q == 4'd0) ? 4'd1 :
              (burst_q < BL) ? burst_q + 4'd1 : burst_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q  <= 1'b1;
      burst_q <= '0;
    end else begin
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end
`endif
  assign gnt0      = state_q == ARB && free && req0 && !sel;
  assign gnt1      = state_q == ARB && free && req1 && sel;
  assign gnt_any   = gnt0 || gnt1;
  assign gx        = sel ? x1 : x0;
  assign gy        = sel ? y1 : y0;
  assign gp        = sel ? pen1 : pen0;
  assign in_range  = gx <= XL && gy <= YL;
  assign oob_drop  = gnt_any && !in_range;
  // once the final clear pixel is loaded, stop loading and wait for its acceptance
  assign clr_load  = state_q == CLEAR && free && !clr_last_q;
  assign clr_final = cx_q == XL && cy_q == YL;
  assign clear_done = state_q == CLEAR && clr_last_q && fb_valid_q && fb_ready;
  assign busy      = state_q == CLEAR;
  assign fb_valid  = fb_valid_q;
  assign fb_x      = fb_x_q;
  assign fb_y      = fb_y_q;
  assign fb_pen    = fb_pen_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB;
      fb_valid_q <= 1'b0;
      fb_x_q     <= '0;
      fb_y_q     <= '0;
      fb_pen_q   <= 1'b0;
      cx_q       <= '0;
      cy_q       <= '0;
      clr_last_q <= 1'b0;
    end else begin
      if (clr_load) begin
        fb_valid_q <= 1'b1;
        fb_x_q     <= cx_q;
        fb_y_q     <= cy_q;
        fb_pen_q   <= 1'b0;
      end else if (gnt_any && in_range) begin
        fb_valid_q <= 1'b1;
        fb_x_q     <= gx;
        fb_y_q     <= gy;
        fb_pen_q   <= gp;
      end else if (fb_ready) begin
        fb_valid_q <= 1'b0;
      end
      if (state_q == ARB) begin
        if (clear_start) state_q <= CLEAR;
      end else if (clear_done) begin
        state_q    <= ARB;
        cx_q       <= '0;
        cy_q       <= '0;
        clr_last_q <= 1'b0;
      end else if (clr_load) begin
        clr_last_q <= clr_final;
        cx_q       <= clr_final ? cx_q : (cx_q == XL ? '0 : cx_q + 10'd1);
        cy_q       <= (clr_final || cx_q != XL) ? cy_q : cy_q + 9'd1;
      end
    end
  end
endmodule

// File: tb/tb_draw_arbiter.sv
// tb_draw_arbiter: self-checking bench for draw_arbiter (640x480 instance and a 4x2 instance for clear sweeps)
module tb_draw_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       reset, req0, req1, pen0, pen1, clear_start, fb_ready;
  logic [9:0] x0, x1, fb_x;
  logic [8:0] y0, y1, fb_y;
  logic       gnt0, gnt1, clear_done, busy, oob_drop, fb_valid, fb_pen;
  logic       s_reset, s_req0, s_req1, s_pen0, s_pen1, s_clear_start, s_fb_ready;
  logic [9:0] s_x0, s_x1, s_fb_x;
  logic [8:0] s_y0, s_y1, s_fb_y;
  logic       s_gnt0, s_gnt1, s_clear_done, s_busy, s_oob_drop, s_fb_valid, s_fb_pen;
  draw_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .x0(x0), .y0(y0), .pen0(pen0), .gnt0(gnt0),
    .req1(req1), .x1(x1), .y1(y1), .pen1(pen1), .gnt1(gnt1),
    .clear_start(clear_start), .clear_done(clear_done), .busy(busy), .oob_drop(oob_drop),
    .fb_valid(fb_valid), .fb_x(fb_x), .fb_y(fb_y), .fb_pen(fb_pen), .fb_ready(fb_ready)
  );
  draw_arbiter #(.XMAX(4), .YMAX(2), .BURST(4)) sdut (
    .clk(clk), .reset(s_reset),
    .req0(s_req0), .x0(s_x0), .y0(s_y0), .pen0(s_pen0), .gnt0(s_gnt0),
    .req1(s_req1), .x1(s_x1), .y1(s_y1), .pen1(s_pen1), .gnt1(s_gnt1),
    .clear_start(s_clear_start), .clear_done(s_clear_done), .busy(s_busy), .oob_drop(s_oob_drop),
    .fb_valid(s_fb_valid), .fb_x(s_fb_x), .fb_y(s_fb_y), .fb_pen(s_fb_pen), .fb_ready(s_fb_ready)
  );
  int n_chk = 0;
  int n_pass = 0;
  logic [19:0] mq[$];
  logic [19:0] sq[$];
  typedef struct {
    logic       r0, r1, p0, p1, rdy;
    logic [9:0] x0, x1;
    logic [8:0] y0, y1;
    logic [3:0] e;
  } vec_t;
  vec_t vecs[$];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t mk(input logic r0, r1, input int ax0, ay0, input logic p0,
                              input int ax1, ay1, input logic p1, rdy, input logic [3:0] e);
    vec_t m;
    m.r0 = r0; m.r1 = r1; m.p0 = p0; m.p1 = p1; m.rdy = rdy; m.e = e;
    m.x0 = 10'(ax0); m.y0 = 9'(ay0); m.x1 = 10'(ax1); m.y1 = 9'(ay1);
    return m;
  endfunction
  always @(negedge clk)
    if (fb_valid === 1'b1 && fb_ready === 1'b1) begin
      if (mq.size() == 0) begin
        n_chk++;
        $display("FAIL main_extra: got pixel %0h, expected none", {fb_x, fb_y, fb_pen});
      end else chk("main_pix", {fb_x, fb_y, fb_pen}, mq.pop_front());
    end
  always @(negedge clk)
    if (s_fb_valid === 1'b1 && s_fb_ready === 1'b1) begin
      if (sq.size() == 0) begin
        n_chk++;
        $display("FAIL small_extra: got pixel %0h, expected none", {s_fb_x, s_fb_y, s_fb_pen});
      end else chk("small_pix", {s_fb_x, s_fb_y, s_fb_pen}, sq.pop_front());
    end
  initial begin
    vec_t v;
    // e = {gnt0, gnt1, oob_drop, fb_valid}
    vecs.push_back(mk(1,1, 10,1,1,  30,2,0, 1, 4'b1000));
    vecs.push_back(mk(1,1, 11,1,1,  30,2,0, 1, 4'b1001));
    vecs.push_back(mk(1,1, 12,1,1,  30,2,0, 1, 4'b1001));
    vecs.push_back(mk(1,1, 13,1,1,  30,2,0, 1, 4'b1001));
    vecs.push_back(mk(1,1, 14,1,1,  31,2,0, 1, 4'b0101));
    vecs.push_back(mk(1,1, 14,1,1,  32,2,0, 1, 4'b0101));
    vecs.push_back(mk(1,1, 14,1,1,  33,2,0, 1, 4'b0101));
    vecs.push_back(mk(1,1, 14,1,1,  34,2,0, 1, 4'b0101));
    vecs.push_back(mk(1,1, 14,1,1,  35,2,0, 1, 4'b1001));
    vecs.push_back(mk(0,1, 0,0,0,   640,5,1, 1, 4'b0111));
    vecs.push_back(mk(0,1, 0,0,0,   639,479,1, 1, 4'b0100));
    vecs.push_back(mk(0,0, 0,0,0,   0,0,0, 1, 4'b0001));
    vecs.push_back(mk(1,0, 5,480,0, 0,0,0, 1, 4'b1010));
    vecs.push_back(mk(0,0, 0,0,0,   0,0,0, 1, 4'b0000));
    vecs.push_back(mk(0,1, 0,0,0,   100,7,1, 1, 4'b0100));
    vecs.push_back(mk(0,1, 0,0,0,   101,7,1, 1, 4'b0101));
    vecs.push_back(mk(0,1, 0,0,0,   102,7,1, 1, 4'b0101));
    vecs.push_back(mk(1,1, 200,8,0, 110,9,1, 1, 4'b0101));
    vecs.push_back(mk(1,1, 200,8,0, 111,9,1, 1, 4'b1001));
    vecs.push_back(mk(1,1, 201,8,0, 111,9,1, 1, 4'b1001));
    vecs.push_back(mk(0,0, 0,0,0,   0,0,0, 1, 4'b0001));
    vecs.push_back(mk(1,1, 202,8,0, 111,9,1, 1, 4'b1000));
    vecs.push_back(mk(1,1, 203,8,0, 111,9,1, 0, 4'b0001));
    vecs.push_back(mk(1,1, 203,8,0, 111,9,1, 1, 4'b1001));
    vecs.push_back(mk(0,0, 0,0,0,   0,0,0, 1, 4'b0001));
    reset = 1'b1; req0 = 0; req1 = 0; x0 = '0; y0 = '0; pen0 = 0; x1 = '0; y1 = '0; pen1 = 0;
    clear_start = 0; fb_ready = 0;
    s_reset = 1'b1; s_req0 = 0; s_req1 = 0; s_x0 = '0; s_y0 = '0; s_pen0 = 0; s_x1 = '0; s_y1 = '0;
    s_pen1 = 0; s_clear_start = 0; s_fb_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    s_reset = 1'b0;
    @(negedge clk);
    chk("main_reset", {fb_valid, fb_x, fb_y, fb_pen, gnt0, gnt1, clear_done, busy, oob_drop}, '0);
    chk("small_reset", {s_fb_valid, s_fb_x, s_fb_y, s_fb_pen, s_busy, s_clear_done}, '0);
    tick;
    foreach (vecs[i]) begin
      v = vecs[i];
      req0 = v.r0; x0 = v.x0; y0 = v.y0; pen0 = v.p0;
      req1 = v.r1; x1 = v.x1; y1 = v.y1; pen1 = v.p1;
      fb_ready = v.rdy;
      if (v.e[3] && !v.e[1]) mq.push_back({v.x0, v.y0, v.p0});
      if (v.e[2] && !v.e[1]) mq.push_back({v.x1, v.y1, v.p1});
      @(negedge clk);
      chk($sformatf("vec%0d", i), {gnt0, gnt1, oob_drop, fb_valid, busy, clear_done}, {v.e, 2'b00});
      tick;
    end
    req0 = 1; x0 = 10; y0 = 20; pen0 = 1; req1 = 0; fb_ready = 1;
    mq.push_back({10'd10, 9'd20, 1'b1});
    @(negedge clk);
    chk("stall_grant", {gnt0, gnt1, oob_drop}, 3'b100);
    tick;
    for (int k = 0; k < 3; k++) begin
      req0 = 1; x0 = 50; y0 = 60; pen0 = 0; req1 = 1; x1 = 70; y1 = 80; pen1 = 1; fb_ready = 0;
      @(negedge clk);
      chk($sformatf("stall_hold%0d", k), {gnt0, gnt1, fb_valid, fb_x, fb_y, fb_pen},
          {1'b0, 1'b0, 1'b1, 10'd10, 9'd20, 1'b1});
      tick;
    end
    fb_ready = 1;
    mq.push_back({10'd70, 9'd80, 1'b1});
    @(negedge clk);
    chk("stall_release", {gnt0, gnt1}, 2'b01);
    tick;
    req0 = 0; req1 = 0;
    @(negedge clk);
    chk("stall_latency", fb_valid, 1'b1);
    tick;
    s_clear_start = 1; s_fb_ready = 1;
    for (int y = 0; y < 2; y++) for (int x = 0; x < 4; x++) sq.push_back({10'(x), 9'(y), 1'b0});
    @(negedge clk);
    chk("clr1_start", {s_busy, s_gnt0, s_clear_done}, 3'b000);
    tick;
    for (int k = 1; k <= 10; k++) begin
      s_clear_start = (k == 4); s_req0 = 1; s_x0 = 2; s_y0 = 1; s_pen0 = 1;
      if (k == 10) sq.push_back({10'd2, 9'd1, 1'b1});
      @(negedge clk);
      chk($sformatf("clr1_k%0d", k), {s_busy, s_gnt0, s_clear_done}, {k <= 9, k == 10, k == 9});
      tick;
    end
    s_req0 = 0; s_clear_start = 0;
    @(negedge clk);
    tick;
    s_req1 = 1; s_x1 = 2; s_y1 = 0; s_pen1 = 1; s_fb_ready = 1;
    sq.push_back({10'd2, 9'd0, 1'b1});
    @(negedge clk);
    chk("clr2_grant", {s_gnt0, s_gnt1, s_busy}, 3'b010);
    tick;
    for (int k = 1; k <= 12; k++) begin
      s_req1 = 0; s_clear_start = (k == 1) || (k == 6); s_fb_ready = (k >= 3);
      if (k == 1) for (int y = 0; y < 2; y++) for (int x = 0; x < 4; x++) sq.push_back({10'(x), 9'(y), 1'b0});
      @(negedge clk);
      chk($sformatf("clr2_k%0d", k), {s_busy, s_clear_done, s_gnt0, s_gnt1},
          {k >= 2 && k <= 11, k == 11, 2'b00});
      if (k == 2) chk("clr2_held", {s_fb_valid, s_fb_x, s_fb_y, s_fb_pen}, {1'b1, 10'd2, 9'd0, 1'b1});
      tick;
    end
    s_clear_start = 1; s_req0 = 1; s_x0 = 1; s_y0 = 0; s_pen0 = 1; s_fb_ready = 1;
    sq.push_back({10'd1, 9'd0, 1'b1});
    @(negedge clk);
    chk("rst_coincident", {s_gnt0, s_gnt1, s_busy}, 3'b100);
    tick;
    s_clear_start = 0; s_req0 = 0;
    @(negedge clk);
    chk("rst_in_clear", s_busy, 1'b1);
    tick;
    s_reset = 1; s_fb_ready = 0;
    @(negedge clk);
    chk("rst_before", {s_busy, s_fb_valid, s_fb_x, s_fb_y, s_fb_pen}, {1'b1, 1'b1, 10'd0, 9'd0, 1'b0});
    tick;
    s_reset = 0; s_req0 = 1; s_x0 = 3; s_y0 = 1; s_pen0 = 1; s_req1 = 1; s_x1 = 0; s_y1 = 0; s_pen1 = 0;
    s_fb_ready = 1;
    sq.push_back({10'd3, 9'd1, 1'b1});
    @(negedge clk);
    chk("rst_after", {s_fb_valid, s_fb_x, s_fb_y, s_fb_pen, s_gnt0, s_gnt1, s_clear_done, s_busy, s_oob_drop},
        {1'b0, 10'd0, 9'd0, 1'b0, 1'b1, 1'b0, 3'b000});
    tick;
    s_req0 = 0; s_req1 = 0;
    @(negedge clk);
    chk("rst_arb", s_busy, 1'b0);
    tick;
    chk("main_drain", mq.size(), 0);
    chk("small_drain", sq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/draw_arbiter.md
Name: draw_arbiter

Overview:
- Shares the single framebuffer pixel-write port between two drawing requesters, e.g. the wave drawer and an overlay/text drawer.
- Uses burst-limited round-robin arbitration.
- Contains an internal full-screen clear sequencer that takes over the port for one complete sweep.
- Sits between the drawers and the VGA framebuffer write interface.

Parameters:
- XMAX, 640, horizontal resolution; valid x is 0..XMAX-1.
- YMAX, 480, vertical resolution; valid y is 0..YMAX-1.
- BURST, 4, maximum consecutive grants to one requester while the other is waiting (1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0  in  1  requester 0 has a pixel
- x0  in  10  requester 0 x
- y0  in  9  requester 0 y
- pen0  in  1  requester 0 colour (1 = draw, 0 = erase)
- gnt0  out  1  requester 0 pixel accepted this cycle
- req1, x1, y1, pen1, gnt1  same as requester 0, for requester 1
- clear_start  in  1  pulse: begin full-screen clear
- clear_done  out  1  one-cycle pulse when the last clear pixel is accepted
- busy  out  1  high while in CLEAR
- oob_drop  out  1  one-cycle pulse when a granted pixel is out of range
- fb_valid  out  1  output pixel valid
- fb_x  out  10  output x
- fb_y  out  9  output y
- fb_pen  out  1  output colour
- fb_ready  in  1  framebuffer accepts the pixel

Behaviour:
- Reset values: fb_valid=0, fb_x=0, fb_y=0, fb_pen=0, gnt0=gnt1=0, clear_done=0, busy=0, oob_drop=0. State=ARB, last-grant pointer=1 (requester 0 wins first), burst count=0, clear counters=0.
- Output register:
  - Can load when free = !fb_valid || fb_ready.
  - Holds all fb_* stable while fb_valid && !fb_ready.
  - fb_valid clears after acceptance if nothing new is loaded.
  - Throughput is one pixel per cycle when fb_ready is held high.
- gnt (combinational):
  - gnt_i = (state==ARB) && free && req_i && (selected == i).
  - A transfer happens when req_i && gnt_i; the requester must hold x/y/pen stable until granted.
  - The granted pixel appears on fb_* the next cycle (latency 1).
- Arbitration in ARB:
  - Only one requester active: it wins.
  - Both active:
    - Last-granted requester keeps priority while burst count < BURST.
    - After BURST consecutive grants, the other requester wins and burst count resets to 1.
  - Switching to a different requester sets burst count to 1.
  - Cycles with no grant leave the pointer and burst count unchanged.
- Range check:
  - A granted pixel with x >= XMAX or y >= YMAX is consumed (gnt asserted) but not loaded.
  - fb_valid is not set for it; oob_drop pulses in the same cycle as the gnt.
- CLEAR state:
  - Entered the cycle after clear_start is sampled in ARB.
  - busy=1 from that cycle; gnt0=gnt1=0 throughout.
  - Each free cycle loads (cx, cy, pen=0).
  - Sweep order: cx 0..XMAX-1 inner, cy 0..YMAX-1 outer, advancing only on load.
  - A pixel already pending in the output register at entry completes normally before the first clear pixel.
  - clear_done pulses the cycle fb_ready accepts pixel (XMAX-1, YMAX-1).
  - On that same cycle the state returns to ARB, busy drops, and cx/cy reset to 0.
  - clear_start during CLEAR is ignored.
  - Arbitration pointer and burst count are preserved across CLEAR.
- Simultaneous events: clear_start coincident with a request in ARB. The request is still granted that cycle if selected and free; CLEAR begins next cycle.
- Reset mid-operation (any state): returns to reset values immediately on the next edge; a pending fb pixel is discarded.

Optional Feature:
- Macro: DRAW_ARB_FIXED_PRIORITY_EN.
- Defined:
  - Requester 0 always wins when both request; BURST is ignored.
  - Pointer and burst count are not implemented.
- Undefined: burst-limited round-robin as above.
- Range check and CLEAR behaviour are identical in both builds.

Test Plan:
- Both requesters hold req, fb_ready=1, BURST=4 -> grant sequence 0,0,0,0,1,1,1,1,0; each pixel appears on fb_* one cycle after its gnt.
- Requester 0 at (10,20,pen=1) granted, fb_ready=0 for 3 cycles -> fb_x=10, fb_y=20, fb_pen=1 held; gnt0/gnt1 stay 0 until fb_ready=1.
- Requester 1 sends x=640,y=5 -> gnt1=1 and oob_drop=1 in the same cycle; fb_valid stays 0. Next pixel (639,479) is forwarded.
- Small config XMAX=4, YMAX=2: clear_start with fb_ready=1 ->
  - busy=1 for 8 loads (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1), all pen=0.
  - clear_done one cycle at acceptance of (3,1); req0 held throughout is first granted after busy falls.
- clear_start while a pixel is stalled (fb_ready=0) -> the stalled pixel is accepted first, then (0,0,pen=0); a second clear_start mid-sweep changes nothing.
- Assert reset for one cycle mid-CLEAR -> all outputs 0 next cycle; state ARB; requester 0 granted first.
